// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit:
// opcodes, funct codes, FSM states, instruction classes and datapath select codes.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF     = 3'b000,
        ST_ID     = 3'b001,
        ST_EXE_AL = 3'b010,
        ST_EXE_BR = 3'b011,
        ST_EXE_LS = 3'b100,
        ST_MEM    = 3'b101,
        ST_WB_AL  = 3'b110,
        ST_WB_LD  = 3'b111
    } state_e;

    typedef enum logic [3:0] {
        CLS_NOP  = 4'd0,
        CLS_RALU = 4'd1,
        CLS_IALU = 4'd2,
        CLS_BEQ  = 4'd3,
        CLS_BNE  = 4'd4,
        CLS_LW   = 4'd5,
        CLS_SW   = 4'd6,
        CLS_J    = 4'd7,
        CLS_JAL  = 4'd8,
        CLS_JR   = 4'd9,
        CLS_HALT = 4'd10
    } instr_class_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_RS     = 2'b10;
    localparam logic [1:0] PCSRC_JUMP   = 2'b11;

    localparam logic [1:0] REGDST_RA = 2'b00;
    localparam logic [1:0] REGDST_RT = 2'b01;
    localparam logic [1:0] REGDST_RD = 2'b10;

    function automatic logic [2:0] alu_op_from_funct(input logic [5:0] fn);
        logic [2:0] res;
        case (fn)
            FN_ADD:  res = ALU_ADD;
            FN_SUB:  res = ALU_SUB;
            FN_AND:  res = ALU_AND;
            FN_OR:   res = ALU_OR;
            FN_SLT:  res = ALU_SLT;
            default: res = ALU_ADD;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decode: op/funct to instruction class, ALU function
// and immediate extension mode. Unknown encodings fall into the nop class.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]   op,
    input  logic [5:0]   funct,
    output instr_class_e iclass,
    output logic [2:0]   alu_op,
    output logic         ext_sign
);

    // Classify the instruction and pick its ALU function
    always_comb begin
        iclass   = CLS_NOP;
        alu_op   = ALU_ADD;
        ext_sign = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
                        iclass = CLS_RALU;
                        alu_op = alu_op_from_funct(funct);
                    end
                    FN_JR:   iclass = CLS_JR;
                    default: iclass = CLS_NOP;
                endcase
            end
            OP_ADDI: begin
                iclass   = CLS_IALU;
                alu_op   = ALU_ADD;
                ext_sign = 1'b1;
            end
            OP_ORI: begin
                iclass = CLS_IALU;
                alu_op = ALU_OR;
            end
            OP_LW:   iclass = CLS_LW;
            OP_SW:   iclass = CLS_SW;
            OP_BEQ:  iclass = CLS_BEQ;
            OP_BNE:  iclass = CLS_BNE;
            OP_J:    iclass = CLS_J;
            OP_JAL:  iclass = CLS_JAL;
            OP_HALT: iclass = CLS_HALT;
            default: iclass = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle sequencing controller: IF/ID/EXE/MEM/WB FSM driving datapath
// enables and selects, with a sticky halt and a retired-instruction counter.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             PCWre,
    output logic [1:0]       PCSrc,
    output logic             IRWre,
    output logic             RegWre,
    output logic [1:0]       RegDst,
    output logic             WrRegDSrc,
    output logic             ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic             ExtSel,
    output logic             mRD,
    output logic             mWR,
    output logic             DBDataSrc,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    state_e           state_r;
    state_e           state_nxt_s;
    logic             halted_r;
    logic             halted_nxt_s;
    logic [5:0]       op_r;
    logic [5:0]       funct_r;
    logic [5:0]       dec_op_s;
    logic [5:0]       dec_funct_s;
    instr_class_e     iclass_s;
    logic [2:0]       alu_op_s;
    logic             ext_sign_s;
    logic [CNT_W-1:0] cnt_r;

    // ID decodes the live IR; every later state works from the latched copy
    assign dec_op_s    = (state_r == ST_ID) ? op    : op_r;
    assign dec_funct_s = (state_r == ST_ID) ? funct : funct_r;

    mc_decode u_decode (
        .op       (dec_op_s),
        .funct    (dec_funct_s),
        .iclass   (iclass_s),
        .alu_op   (alu_op_s),
        .ext_sign (ext_sign_s)
    );

    // State and sticky halt flag registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r  <= ST_IF;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            halted_r <= halted_nxt_s;
        end
    end

    // Capture op/funct on the edge leaving ID
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            op_r    <= 6'b000000;
            funct_r <= 6'b000000;
        end else if ((state_r == ST_ID) && !halted_r) begin
            op_r    <= op;
            funct_r <= funct;
        end
    end

    // Next-state logic; HALT is ID with the halted flag held forever
    always_comb begin
        state_nxt_s  = state_r;
        halted_nxt_s = halted_r;
        case (state_r)
            ST_IF: state_nxt_s = ST_ID;
            ST_ID: begin
                if (halted_r) begin
                    state_nxt_s = ST_ID;
                end else begin
                    case (iclass_s)
                        CLS_HALT: begin
                            state_nxt_s  = ST_ID;
                            halted_nxt_s = 1'b1;
                        end
                        CLS_BEQ, CLS_BNE:   state_nxt_s = ST_EXE_BR;
                        CLS_LW, CLS_SW:     state_nxt_s = ST_EXE_LS;
                        CLS_RALU, CLS_IALU: state_nxt_s = ST_EXE_AL;
                        default:            state_nxt_s = ST_IF;
                    endcase
                end
            end
            ST_EXE_AL: state_nxt_s = ST_WB_AL;
            ST_EXE_BR: state_nxt_s = ST_IF;
            ST_EXE_LS: state_nxt_s = ST_MEM;
            ST_MEM: begin
                if (iclass_s == CLS_LW) begin
                    state_nxt_s = ST_WB_LD;
                end else begin
                    state_nxt_s = ST_IF;
                end
            end
            ST_WB_AL: state_nxt_s = ST_IF;
            ST_WB_LD: state_nxt_s = ST_IF;
            default:  state_nxt_s = ST_IF;
        endcase
    end

    // Datapath controls decoded from state, latched fields and zero
    always_comb begin
        PCWre     = 1'b0;
        PCSrc     = PCSRC_SEQ;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        RegDst    = REGDST_RA;
        WrRegDSrc = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = ALU_ADD;
        ExtSel    = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        DBDataSrc = 1'b0;
        case (state_r)
            ST_IF: IRWre = 1'b1;
            ST_ID: begin
                if (!halted_r) begin
                    case (iclass_s)
                        CLS_J: begin
                            PCWre = 1'b1;
                            PCSrc = PCSRC_JUMP;
                        end
                        CLS_JAL: begin
                            PCWre     = 1'b1;
                            PCSrc     = PCSRC_JUMP;
                            RegWre    = 1'b1;
                            RegDst    = REGDST_RA;
                            WrRegDSrc = 1'b0;
                        end
                        CLS_JR: begin
                            PCWre = 1'b1;
                            PCSrc = PCSRC_RS;
                        end
                        CLS_NOP: begin
                            PCWre = 1'b1;
                            PCSrc = PCSRC_SEQ;
                        end
                        default: PCWre = 1'b0;
                    endcase
                end else begin
                    PCWre = 1'b0;
                end
            end
            ST_EXE_AL: begin
                ALUOp   = alu_op_s;
                ALUSrcB = (iclass_s == CLS_IALU);
                ExtSel  = ext_sign_s;
            end
            ST_WB_AL: begin
                ALUOp     = alu_op_s;
                ALUSrcB   = (iclass_s == CLS_IALU);
                ExtSel    = ext_sign_s;
                RegWre    = 1'b1;
                RegDst    = (iclass_s == CLS_RALU) ? REGDST_RD : REGDST_RT;
                WrRegDSrc = 1'b1;
                DBDataSrc = 1'b0;
                PCWre     = 1'b1;
                PCSrc     = PCSRC_SEQ;
            end
            ST_EXE_BR: begin
                ALUOp  = ALU_SUB;
                ExtSel = 1'b1;
                PCWre  = 1'b1;
                if (((iclass_s == CLS_BEQ) && zero) || ((iclass_s == CLS_BNE) && !zero)) begin
                    PCSrc = PCSRC_BRANCH;
                end else begin
                    PCSrc = PCSRC_SEQ;
                end
            end
            ST_EXE_LS: begin
                ALUOp   = ALU_ADD;
                ALUSrcB = 1'b1;
                ExtSel  = 1'b1;
            end
            ST_MEM: begin
                if (iclass_s == CLS_LW) begin
                    mRD = 1'b1;
                end else begin
                    mWR   = 1'b1;
                    PCWre = 1'b1;
                    PCSrc = PCSRC_SEQ;
                end
            end
            ST_WB_LD: begin
                mRD       = 1'b1;
                DBDataSrc = 1'b1;
                WrRegDSrc = 1'b1;
                RegDst    = REGDST_RT;
                RegWre    = 1'b1;
                PCWre     = 1'b1;
                PCSrc     = PCSRC_SEQ;
            end
            default: IRWre = 1'b0;
        endcase
    end

    // Retired-instruction counter, one step per PC write
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (PCWre) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign state     = state_r;
    assign instr_cnt = cnt_r;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: checks state sequence, controls and counter
// on a default instance and a 2-bit-counter instance driven in lockstep.
module tb_mc_control_unit;

    logic        CLK;
    logic        RST;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;

    logic        PCWre, IRWre, RegWre, WrRegDSrc, ALUSrcB, ExtSel, mRD, mWR, DBDataSrc;
    logic [1:0]  PCSrc, RegDst;
    logic [2:0]  ALUOp, state;
    logic [31:0] instr_cnt;

    logic        PCWre_b, IRWre_b, RegWre_b, WrRegDSrc_b, ALUSrcB_b, ExtSel_b, mRD_b, mWR_b, DBDataSrc_b;
    logic [1:0]  PCSrc_b, RegDst_b;
    logic [2:0]  ALUOp_b, state_b;
    logic [1:0]  instr_cnt_b;

    logic [15:0] ctl_a, ctl_b;
    logic [31:0] exp_cnt;
    int          n_assert = 0;
    int          n_fail   = 0;

    localparam logic [2:0] S_IF = 3'b000, S_ID = 3'b001, S_EAL = 3'b010, S_EBR = 3'b011;
    localparam logic [2:0] S_ELS = 3'b100, S_MEM = 3'b101, S_WAL = 3'b110, S_WLD = 3'b111;

    mc_control_unit #(.CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .op(op), .funct(funct), .zero(zero),
        .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .RegWre(RegWre), .RegDst(RegDst),
        .WrRegDSrc(WrRegDSrc), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel),
        .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc), .state(state), .instr_cnt(instr_cnt)
    );

    mc_control_unit #(.CNT_W(2)) dut_b (
        .CLK(CLK), .RST(RST), .op(op), .funct(funct), .zero(zero),
        .PCWre(PCWre_b), .PCSrc(PCSrc_b), .IRWre(IRWre_b), .RegWre(RegWre_b), .RegDst(RegDst_b),
        .WrRegDSrc(WrRegDSrc_b), .ALUSrcB(ALUSrcB_b), .ALUOp(ALUOp_b), .ExtSel(ExtSel_b),
        .mRD(mRD_b), .mWR(mWR_b), .DBDataSrc(DBDataSrc_b), .state(state_b), .instr_cnt(instr_cnt_b)
    );

    assign ctl_a = {PCWre, PCSrc, IRWre, RegWre, RegDst, WrRegDSrc, ALUSrcB, ALUOp,
                    ExtSel, mRD, mWR, DBDataSrc};
    assign ctl_b = {PCWre_b, PCSrc_b, IRWre_b, RegWre_b, RegDst_b, WrRegDSrc_b, ALUSrcB_b,
                    ALUOp_b, ExtSel_b, mRD_b, mWR_b, DBDataSrc_b};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [15:0] ctl(input logic pcwre, input logic [1:0] pcsrc,
                                        input logic irwre, input logic regwre,
                                        input logic [1:0] regdst, input logic wrsrc,
                                        input logic alusrcb, input logic [2:0] aluop,
                                        input logic extsel, input logic mrd,
                                        input logic mwr, input logic dbsrc);
        return {pcwre, pcsrc, irwre, regwre, regdst, wrsrc, alusrcb, aluop, extsel, mrd, mwr, dbsrc};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check the current cycle on both instances, then advance one clock
    task automatic cyc(input string tag, input logic [2:0] est, input logic [15:0] ectl);
        check({tag, "_state"}, {61'd0, state}, {61'd0, est});
        check({tag, "_ctl"}, {48'd0, ctl_a}, {48'd0, ectl});
        check({tag, "_cnt"}, {32'd0, instr_cnt}, {32'd0, exp_cnt});
        check({tag, "_state_b"}, {61'd0, state_b}, {61'd0, est});
        check({tag, "_ctl_b"}, {48'd0, ctl_b}, {48'd0, ectl});
        check({tag, "_cnt_b"}, {62'd0, instr_cnt_b}, {62'd0, exp_cnt[1:0]});
        @(posedge CLK);
        #2;
        if (ectl[15]) exp_cnt = exp_cnt + 32'd1;
    endtask

    logic [15:0] c_if;

    initial begin
        c_if    = ctl(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_cnt = 32'd0;
        RST     = 1'b0;
        op      = 6'b000000;
        funct   = 6'b100000;
        zero    = 1'b0;
        #3;
        check("reset_state", {61'd0, state}, 64'd0);
        check("reset_ctl", {48'd0, ctl_a}, {48'd0, c_if});
        check("reset_cnt", {32'd0, instr_cnt}, 64'd0);
        @(negedge CLK);
        RST = 1'b1;

        // add
        cyc("add_if", S_IF, c_if);
        cyc("add_id", S_ID, 16'h0000);
        cyc("add_exe", S_EAL, 16'h0000);
        cyc("add_wb", S_WAL, ctl(1'b1, 2'b00, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));

        // sub, with the IR changed to j after ID
        funct = 6'b100010;
        cyc("sub_if", S_IF, c_if);
        cyc("sub_id", S_ID, 16'h0000);
        op = 6'b000010; funct = 6'b000000;
        cyc("sub_exe", S_EAL, ctl(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc("sub_wb", S_WAL, ctl(1'b1, 2'b00, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0));

        // ori
        op = 6'b001101;
        cyc("ori_if", S_IF, c_if);
        cyc("ori_id", S_ID, 16'h0000);
        cyc("ori_exe", S_EAL, ctl(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc("ori_wb", S_WAL, ctl(1'b1, 2'b00, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0));

        // addi: fourth retirement wraps the 2-bit counter
        op = 6'b001000;
        cyc("addi_if", S_IF, c_if);
        cyc("addi_id", S_ID, 16'h0000);
        cyc("addi_exe", S_EAL, ctl(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));
        check("cnt_b_all_ones", {62'd0, instr_cnt_b}, 64'd3);
        cyc("addi_wb", S_WAL, ctl(1'b1, 2'b00, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));
        check("cnt_b_wrap", {62'd0, instr_cnt_b}, 64'd0);

        // beq taken / not taken, bne taken
        op = 6'b000100; zero = 1'b1;
        cyc("beq1_if", S_IF, c_if);
        cyc("beq1_id", S_ID, 16'h0000);
        cyc("beq1_br", S_EBR, ctl(1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0));
        zero = 1'b0;
        cyc("beq0_if", S_IF, c_if);
        cyc("beq0_id", S_ID, 16'h0000);
        cyc("beq0_br", S_EBR, ctl(1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0));
        op = 6'b000101;
        cyc("bne0_if", S_IF, c_if);
        cyc("bne0_id", S_ID, 16'h0000);
        cyc("bne0_br", S_EBR, ctl(1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0));

        // lw
        op = 6'b100011;
        cyc("lw_if", S_IF, c_if);
        cyc("lw_id", S_ID, 16'h0000);
        cyc("lw_exe", S_ELS, ctl(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc("lw_mem", S_MEM, ctl(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0));
        cyc("lw_wb", S_WLD, ctl(1'b1, 2'b00, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1));

        // sw
        op = 6'b101011;
        cyc("sw_if", S_IF, c_if);
        cyc("sw_id", S_ID, 16'h0000);
        cyc("sw_exe", S_ELS, ctl(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc("sw_mem", S_MEM, ctl(1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0));

        // jal, jr, j, undefined op, undefined funct
        op = 6'b000011;
        cyc("jal_if", S_IF, c_if);
        cyc("jal_id", S_ID, ctl(1'b1, 2'b11, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
        op = 6'b000000; funct = 6'b001000;
        cyc("jr_if", S_IF, c_if);
        cyc("jr_id", S_ID, ctl(1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
        op = 6'b000010;
        cyc("j_if", S_IF, c_if);
        cyc("j_id", S_ID, ctl(1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
        op = 6'b111000;
        cyc("undef_op_if", S_IF, c_if);
        cyc("undef_op_id", S_ID, 16'h8000);
        op = 6'b000000; funct = 6'b111111;
        cyc("undef_fn_if", S_IF, c_if);
        cyc("undef_fn_id", S_ID, 16'h8000);
        check("cnt_after_14", {32'd0, instr_cnt}, 64'd14);

        // reset asserted during MEM of sw
        op = 6'b101011;
        cyc("rsw_if", S_IF, c_if);
        cyc("rsw_id", S_ID, 16'h0000);
        cyc("rsw_exe", S_ELS, ctl(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));
        check("rsw_mem_mwr", {63'd0, mWR}, 64'd1);
        RST = 1'b0;
        #1;
        exp_cnt = 32'd0;
        check("rsw_rst_mwr", {63'd0, mWR}, 64'd0);
        check("rsw_rst_pcwre", {63'd0, PCWre}, 64'd0);
        check("rsw_rst_cnt", {32'd0, instr_cnt}, 64'd0);
        check("rsw_rst_ctl", {48'd0, ctl_a}, {48'd0, c_if});
        check("rsw_rst_state", {61'd0, state}, 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        op  = 6'b000010;
        cyc("post_rst_if", S_IF, c_if);
        cyc("post_rst_id", S_ID, ctl(1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));

        // halt is absorbing; IR changes are ignored
        op = 6'b111111;
        cyc("halt_if", S_IF, c_if);
        for (int i = 0; i < 21; i++) begin
            if (i == 5) op = 6'b000010;
            cyc("halt", S_ID, 16'h0000);
        end
        check("halt_cnt_frozen", {32'd0, instr_cnt}, 64'd1);
        RST = 1'b0;
        #1;
        exp_cnt = 32'd0;
        check("halt_rst_state", {61'd0, state}, 64'd0);
        check("halt_rst_cnt", {32'd0, instr_cnt}, 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        cyc("restart_if", S_IF, c_if);
        cyc("restart_id", S_ID, ctl(1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
        check("restart_cnt", {32'd0, instr_cnt}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
